sdp_bram_fifo_ctrl: RTL and testbench
=====================================

Name: sdp_bram_fifo_ctrl

Overview:
Synchronous FIFO controller that sits directly in front of a simple-dual-port BRAM (write port: we/wa/wd; read port: ra in, registered rd out one cycle later) and consumes its read data. It converts a valid/ready push/pop stream into BRAM write and read accesses, absorbs the one-cycle BRAM read latency with a 2-entry output buffer, and never reads an address in the same cycle it is written. Sequencing is pointer-based, so the inferred BRAM can be mapped and its read-during-write behaviour left unconstrained.

Parameters:
ABITS, 4, BRAM address width; BRAM depth = 2**ABITS entries
DBITS, 8, data width (write and read widths equal)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  push request
in_ready  output  1  push accepted when in_valid && in_ready
in_data  input  DBITS  push data
out_valid  output  1  head data valid
out_ready  input  1  pop when out_valid && out_ready
out_data  output  DBITS  head data, registered
level  output  ABITS+2  total entries held (BRAM + in-flight + output buffer)
mem_we  output  1  BRAM write enable
mem_wa  output  ABITS  BRAM write address
mem_wd  output  DBITS  BRAM write data
mem_ra  output  ABITS  BRAM read address
mem_rd  input  DBITS  BRAM read data (valid 1 cycle after mem_ra)

Behaviour:
- State: wptr, rptr (ABITS+1 bits, wrap naturally); rd_pending; out register (out_valid/out_data); skid register (skid_valid/skid_data).
- Reset (async, rst_n=0): wptr=rptr=0, rd_pending=0, out_valid=0, skid_valid=0, out_data=0, skid_data=0, level=0. Reset mid-operation discards all contents; in-flight read data arriving after reset release is ignored.
- mem_cnt = wptr - rptr (0..2**ABITS). in_ready = (mem_cnt != 2**ABITS). Combinational.
- push = in_valid && in_ready. mem_we = push; mem_wa = wptr[ABITS-1:0]; mem_wd = in_data; wptr += push.
- pop = out_valid && out_ready. staged = out_valid + skid_valid + rd_pending.
- issue = (mem_cnt != 0) && (staged - pop < 2). mem_ra = rptr[ABITS-1:0] always; rptr += issue; rd_pending <= issue.
- mem_cnt counts only entries written at earlier edges, so an issued read address never equals the same-cycle write address. When issue=0, mem_ra may equal mem_wa; mem_rd in the next cycle is ignored.
- Landing (rd_pending=1): mem_rd goes into out if out is empty or being popped and skid is empty; otherwise it goes into skid.
- On pop: out <- skid if skid_valid (skid cleared), else out <- landing data if present, else out_valid <= 0.
- Ordering is strict FIFO across BRAM, skid and out. Overflow and underflow are impossible by construction; a push when in_ready=0 is ignored.
- Latency: push in cycle N into an empty FIFO -> issue in N+1 -> out_valid=1 in cycle N+3.
- Throughput: 1 push and 1 pop per cycle sustained. Simultaneous push and pop at full or empty are legal.
- level = mem_cnt + staged, registered-equivalent (derived from registers). Max = 2**ABITS + 2.
- Full: in_ready=0 only when BRAM holds 2**ABITS entries. The output buffer adds up to 2 more.

Test Plan:
- Reset: hold rst_n=0, toggle inputs -> out_valid=0, level=0, in_ready=1, mem_we=0. Assert rst_n=0 mid-stream with level=5 -> level=0 immediately.
- Single entry: push 0xA5 at cycle 0 with out_ready=0 -> mem_we=1/mem_wa=0 at cycle 0; mem_ra=0 issued at cycle 1; out_valid=1, out_data=0xA5 at cycle 3; pop -> level=0.
- Fill (ABITS=4), out_ready=0: push 0..19 -> 18 accepted (16 BRAM + 2 buffer), in_ready=0, level=18. Release out_ready -> data 0..17 in order, no gaps after the first.
- Streaming: push and pop every cycle for 100 items with wrap -> out sequence equals in sequence; level steady at 2 or 3; never mem_we && issue with mem_wa==mem_ra.
- Random backpressure: random in_valid/out_ready for 10k cycles -> scoreboard match; level equals pushes minus pops each cycle.
- Same-address hazard: mem_cnt=0 with simultaneous push -> no issue that cycle (rd_pending stays 0); read issued the next cycle returns the pushed data.

Source files
------------

// File: rtl/sdp_bram_fifo_ctrl.sv
// FIFO controller in front of a simple-dual-port BRAM with a one-cycle registered read.
// A 2-entry out/skid buffer hides the read latency so push and pop both sustain one per cycle.
module sdp_bram_fifo_ctrl #(
    parameter int ABITS = 4,
    parameter int DBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DBITS-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DBITS-1:0] out_data,
    output logic [ABITS+1:0] level,
    output logic             mem_we,
    output logic [ABITS-1:0] mem_wa,
    output logic [DBITS-1:0] mem_wd,
    output logic [ABITS-1:0] mem_ra,
    input  logic [DBITS-1:0] mem_rd
);

    localparam logic [ABITS:0] DEPTH = {1'b1, {ABITS{1'b0}}};

    logic [ABITS:0]   wptr_r, rptr_r, mem_cnt_s;
    logic             rd_pending_r, out_valid_r, skid_valid_r;
    logic [DBITS-1:0] out_data_r, skid_data_r;
    logic             push_s, pop_s, issue_s;
    logic [1:0]       staged_s;
    logic [2:0]       staged_after_pop_s;
    logic             out_valid_nx_s, skid_valid_nx_s;
    logic [DBITS-1:0] out_data_nx_s, skid_data_nx_s;

    // mem_cnt only counts entries written at earlier edges, so an issued read never hits the live write address
    assign mem_cnt_s          = wptr_r - rptr_r;
    assign in_ready           = (mem_cnt_s != DEPTH);
    assign push_s             = in_valid && in_ready;
    assign pop_s              = out_valid_r && out_ready;
    assign staged_s           = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, rd_pending_r};
    assign staged_after_pop_s = {1'b0, staged_s} - {2'b00, pop_s};
    assign issue_s            = (mem_cnt_s != {(ABITS+1){1'b0}}) && (staged_after_pop_s < 3'd2);

    assign mem_we    = push_s && rst_n;
    assign mem_wa    = wptr_r[ABITS-1:0];
    assign mem_wd    = in_data;
    assign mem_ra    = rptr_r[ABITS-1:0];
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign level     = {1'b0, mem_cnt_s} + {{ABITS{1'b0}}, staged_s};

    // Steer landing read data and skid contents into the out register while keeping FIFO order
    always_comb begin
        out_valid_nx_s  = out_valid_r;
        out_data_nx_s   = out_data_r;
        skid_valid_nx_s = skid_valid_r;
        skid_data_nx_s  = skid_data_r;
        if (pop_s && skid_valid_r) begin
            out_data_nx_s = skid_data_r;
            if (rd_pending_r) begin
                skid_data_nx_s = mem_rd;
            end else begin
                skid_valid_nx_s = 1'b0;
            end
        end else if (rd_pending_r) begin
            if (!out_valid_r || pop_s) begin
                out_valid_nx_s = 1'b1;
                out_data_nx_s  = mem_rd;
            end else begin
                skid_valid_nx_s = 1'b1;
                skid_data_nx_s  = mem_rd;
            end
        end else if (pop_s) begin
            out_valid_nx_s = 1'b0;
        end else begin
            out_valid_nx_s = out_valid_r;
        end
    end

    // Pointer, pending-read and output buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r       <= {(ABITS+1){1'b0}};
            rptr_r       <= {(ABITS+1){1'b0}};
            rd_pending_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= {DBITS{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DBITS{1'b0}};
        end else begin
            wptr_r       <= wptr_r + {{ABITS{1'b0}}, push_s};
            rptr_r       <= rptr_r + {{ABITS{1'b0}}, issue_s};
            rd_pending_r <= issue_s;
            out_valid_r  <= out_valid_nx_s;
            out_data_r   <= out_data_nx_s;
            skid_valid_r <= skid_valid_nx_s;
            skid_data_r  <= skid_data_nx_s;
        end
    end

endmodule

// File: tb/tb_sdp_bram_fifo_ctrl.sv
// Testbench for sdp_bram_fifo_ctrl: BRAM model that corrupts same-address read-during-write,
// plus a queue scoreboard checking data order and occupancy every cycle.
module tb_sdp_bram_fifo_ctrl;
    localparam int ABITS = 4;
    localparam int DBITS = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DBITS-1:0] in_data = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DBITS-1:0] out_data;
    logic [ABITS+1:0] level;
    logic             mem_we;
    logic [ABITS-1:0] mem_wa, mem_ra;
    logic [DBITS-1:0] mem_wd, mem_rd;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    logic [DBITS-1:0] q[$];
    logic [DBITS-1:0] bram [0:(1<<ABITS)-1];

    sdp_bram_fifo_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_ra(mem_ra), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // BRAM: a read of the address being written returns garbage
    initial for (int i = 0; i < (1<<ABITS); i++) bram[i] = 8'h00;
    always @(posedge clk) begin
        if (mem_we) bram[mem_wa] <= mem_wd;
        mem_rd <= (mem_we && mem_wa == mem_ra) ? ~mem_wd : bram[mem_ra];
    end

    // Scoreboard: level equals accepted pushes minus pops; head data matches oldest entry
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            tests++;
            if (level !== 6'(q.size())) begin
                fails++;
                $display("FAIL sb_level: got %0d expected %0d at %0t", level, q.size(), $time);
            end
            if (out_valid) begin
                tests++;
                if (q.size() == 0 || out_data !== q[0]) begin
                    fails++;
                    $display("FAIL sb_data: got %h expected %h at %0t", out_data,
                             (q.size() == 0) ? 8'hxx : q[0], $time);
                end
            end
            tests++;
            if (!in_ready && q.size() < (1<<ABITS)) begin
                fails++;
                $display("FAIL sb_in_ready: got 0 with %0d entries at %0t", q.size(), $time);
            end
            if (in_valid && in_ready) q.push_back(in_data);
            if (out_valid && out_ready) void'(q.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            in_data   = 8'($urandom);
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0 || level !== 6'd0 || in_ready !== 1'b1 || mem_we !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: out_valid=%b level=%0d in_ready=%b mem_we=%b expected 0 0 1 0",
                         out_valid, level, in_ready, mem_we);
            end
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        q.delete();
        rst_n = 1'b1;
        mon_en = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk);
        tests++;
        if (mem_we !== 1'b1 || mem_wa !== 4'd0 || mem_wd !== 8'hA5) begin
            fails++;
            $display("FAIL single_write: we=%b wa=%0d wd=%h expected 1 0 a5", mem_we, mem_wa, mem_wd);
        end
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_ra !== 4'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_c1: ra=%0d out_valid=%b expected 0 0", mem_ra, out_valid);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (mem_ra !== 4'd1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_c2: ra=%0d out_valid=%b expected 1 0", mem_ra, out_valid);
        end
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            fails++;
            $display("FAIL single_c3: out_valid=%b data=%h expected 1 a5", out_valid, out_data);
        end
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (level !== 6'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_pop: level=%0d out_valid=%b expected 0 0", level, out_valid);
        end
        cyc();
    endtask

    task automatic test_fill();
        int acc = 0;
        int exp = 0;
        bit started = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 8'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        tests++;
        if (acc != 18 || level !== 6'd18 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full: accepted=%0d level=%0d in_ready=%b expected 18 18 0", acc, level, in_ready);
        end
        cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp < 18; i++) begin
            @(negedge clk);
            if (out_valid) begin
                tests++;
                if (out_data !== 8'(exp)) begin
                    fails++;
                    $display("FAIL fill_order: got %h expected %h", out_data, 8'(exp));
                end
                exp++;
                started = 1'b1;
            end else if (started) begin
                tests++;
                fails++;
                $display("FAIL fill_gap: out_valid 0 after %0d items expected 1", exp);
            end
            cyc();
        end
        tests++;
        if (exp != 18) begin
            fails++;
            $display("FAIL fill_drain: got %0d items expected 18", exp);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        int rx = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 50);
            @(negedge clk);
            if (i >= 3) begin
                tests++;
                if (level < 6'd2 || level > 6'd3) begin
                    fails++;
                    $display("FAIL stream_level: got %0d expected 2..3 at item %0d", level, i);
                end
            end
            if (out_valid) begin
                tests++;
                if (out_data !== 8'(rx + 50)) begin
                    fails++;
                    $display("FAIL stream_order: got %h expected %h", out_data, 8'(rx + 50));
                end
                rx++;
            end
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && rx < 100; i++) begin
            @(negedge clk);
            if (out_valid) rx++;
            cyc();
        end
        tests++;
        if (rx != 100) begin
            fails++;
            $display("FAIL stream_count: got %0d expected 100", rx);
        end
    endtask

    task automatic test_hazard();
        logic [ABITS-1:0] ra0;
        out_ready = 1'b1;
        repeat (4) cyc();
        in_valid = 1'b1; in_data = 8'h3C;
        @(negedge clk);
        ra0 = mem_ra;
        tests++;
        if (level !== 6'd0 || mem_we !== 1'b1 || mem_wa !== mem_ra) begin
            fails++;
            $display("FAIL hazard_setup: level=%0d we=%b wa=%0d ra=%0d expected 0 1 equal", level, mem_we, mem_wa, mem_ra);
        end
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_ra !== ra0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL hazard_noissue: ra=%0d out_valid=%b expected %0d 0", mem_ra, out_valid, ra0);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (mem_ra !== ra0 + 4'd1) begin
            fails++;
            $display("FAIL hazard_issue: ra=%0d expected %0d", mem_ra, ra0 + 4'd1);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            fails++;
            $display("FAIL hazard_data: out_valid=%b data=%h expected 1 3c", out_valid, out_data);
        end
        cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            int bias = (i / 1000) % 4;
            in_valid  = ($urandom_range(3, 0) < 32'(bias + 1)) ? 1'b1 : 1'b0;
            out_ready = ($urandom_range(3, 0) < 32'(4 - bias)) ? 1'b1 : 1'b0;
            in_data   = 8'($urandom);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (30) cyc();
        @(negedge clk);
        tests++;
        if (level !== 6'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL random_drain: level=%0d out_valid=%b expected 0 0", level, out_valid);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && level != 6'd5; i++) begin
            in_data = 8'($urandom);
            if (level == 6'd4) in_valid = 1'b1;
            if (level >= 6'd4) begin
                cyc();
                in_valid = 1'b0;
            end else begin
                cyc();
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (level !== 6'd5) begin
            fails++;
            $display("FAIL rstmid_setup: level=%0d expected 5", level);
        end
        cyc();
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (level !== 6'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_async: level=%0d out_valid=%b expected 0 0", level, out_valid);
        end
        cyc();
        rst_n = 1'b1;
        q.delete();
        mon_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            tests++;
            if (level !== 6'd0 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_after: level=%0d out_valid=%b expected 0 0", level, out_valid);
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_hazard();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
